// File: rtl/mdio_pkg.sv
// Shared constants, widths and FSM encoding for the MDIO responder.
package mdio_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DATA_W     = 16;
  // Header shift register: 11 stored bits plus the bit arriving on this rise.
  localparam int unsigned HDR_W      = 11;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Bit indices where header fields complete.
  localparam int unsigned ST_LAST  = 1;
  localparam int unsigned OP_LAST  = 3;
  localparam int unsigned PHY_LAST = 8;
  localparam int unsigned HDR_LAST = 13;
  localparam int unsigned TA_LAST  = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    WRITE  = 3'd2,
    READ   = 3'd3,
    SKIP   = 3'd4
  } state_e;

endpackage

// File: rtl/mdio_receiver_mdc_edge_detect.sv
// MDC edge detector: one-clk rise/fall indications relative to the previous clk.
module mdc_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic mdc_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic mdc_q;

  // Remember MDC from the previous clk.
  always_ff @(posedge clk) begin
    if (reset) mdc_q <= 1'b0;
    else       mdc_q <= mdc_i;
  end

  assign rise_c_o = mdc_i & ~mdc_q;
  assign fall_c_o = ~mdc_i & mdc_q;

endmodule

// File: rtl/mdio_receiver.sv
// Clause-22 MDIO responder: deserialises frames, strobes the register memory,
// and serialises read data back towards the generator.
module mdio_receiver
  import mdio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MDC,
  input  logic              MDIO_OUT,
  input  logic              MDIO_OE,
  output logic              MDIO_IN,
  output logic              MDIO_DONE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              MEM_WR,
  output logic              MEM_RD,
  input  logic [DATA_W-1:0] RD_DATA
);

  localparam logic [CNT_W-1:0] IDX_ST   = CNT_W'(ST_LAST);
  localparam logic [CNT_W-1:0] IDX_OP   = CNT_W'(OP_LAST);
  localparam logic [CNT_W-1:0] IDX_PHY  = CNT_W'(PHY_LAST);
  localparam logic [CNT_W-1:0] IDX_HDR  = CNT_W'(HDR_LAST);
  localparam logic [CNT_W-1:0] IDX_TA   = CNT_W'(TA_LAST);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(FRAME_BITS - 1);

  logic rise_c, fall_c;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   rd_sh_q, rd_sh_d;
  logic                mdio_in_q, mdio_in_d;
  logic                done_q, done_d;
  logic                mem_wr_q, mem_wr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                rd_pend_q, rd_pend_d;

  logic [CNT_W-1:0]    next_idx;
  logic [HDR_W:0]      hdr_next;

  mdc_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .mdc_i    (MDC),
    .rise_c_o (rise_c),
    .fall_c_o (fall_c)
  );

  assign next_idx = cnt_q + CNT_W'(1);
  // Header bits so far, newest bit in the LSB.
  assign hdr_next = {hdr_q, MDIO_OUT};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: header field checks happen on the rise completing each field.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise_c && MDIO_OE) state_d = HEADER;
      end
      HEADER: begin
        if (rise_c) begin
          if (next_idx == IDX_ST && hdr_next[1:0] != ST_CODE) begin
            state_d = IDLE;
          end else if (next_idx == IDX_OP && hdr_next[1:0] != OP_WRITE
                       && hdr_next[1:0] != OP_READ) begin
            state_d = SKIP;
          end else if (next_idx == IDX_PHY && hdr_next[4:0] != PHY_ADDR) begin
            state_d = SKIP;
          end else if (next_idx == IDX_HDR) begin
            state_d = (hdr_next[11:10] == OP_WRITE) ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (rise_c && (!MDIO_OE || next_idx == IDX_LAST)) state_d = IDLE;
      end
      READ, SKIP: begin
        if (rise_c && next_idx == IDX_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values.
  always_comb begin
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_sh_d   = rd_sh_q;
    mdio_in_d = mdio_in_q;
    done_d    = 1'b0;
    mem_wr_d  = 1'b0;
    mem_rd_d  = 1'b0;
    rd_pend_d = mem_rd_q;
    // Memory data is valid the clk after the read strobe.
    if (rd_pend_q) rd_sh_d = RD_DATA;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        mdio_in_d = 1'b0;
        if (rise_c && MDIO_OE) hdr_d = {{(HDR_W-1){1'b0}}, MDIO_OUT};
      end
      HEADER: begin
        if (rise_c) begin
          cnt_d = next_idx;
          hdr_d = hdr_next[HDR_W-1:0];
          if (next_idx == IDX_HDR) begin
            addr_d   = hdr_next[4:0];
            mem_rd_d = (hdr_next[11:10] == OP_READ);
          end
        end
      end
      WRITE: begin
        if (rise_c) begin
          cnt_d = next_idx;
          if (MDIO_OE) begin
            if (next_idx > IDX_TA) wr_data_d = {wr_data_q[DATA_W-2:0], MDIO_OUT};
            if (next_idx == IDX_LAST) begin
              mem_wr_d = 1'b1;
              done_d   = 1'b1;
            end
          end
        end
      end
      READ: begin
        if (rise_c) begin
          cnt_d = next_idx;
          if (next_idx == IDX_LAST) begin
            done_d    = 1'b1;
            mdio_in_d = 1'b0;
          end
        end else if (fall_c && cnt_q >= IDX_TA) begin
          mdio_in_d = rd_sh_q[DATA_W-1];
          rd_sh_d   = {rd_sh_q[DATA_W-2:0], 1'b0};
        end
      end
      SKIP: begin
        if (rise_c) cnt_d = next_idx;
      end
      default: begin
        cnt_d     = '0;
        mdio_in_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hdr_q     <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_sh_q   <= '0;
      mdio_in_q <= 1'b0;
      done_q    <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_sh_q   <= rd_sh_d;
      mdio_in_q <= mdio_in_d;
      done_q    <= done_d;
      mem_wr_q  <= mem_wr_d;
      mem_rd_q  <= mem_rd_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign MDIO_IN   = mdio_in_q;
  assign MDIO_DONE = done_q;
  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;
  assign MEM_WR    = mem_wr_q;
  assign MEM_RD    = mem_rd_q;

endmodule

// File: tb/tb_mdio_receiver.sv
// Bench for mdio_receiver: acts as MDIO generator and register memory,
// checks effects of each frame against a frame-level reference model.
module tb_mdio_receiver;

  localparam logic [4:0] PHY = 5'd0;

  logic        clk = 1'b0;
  logic        reset, MDC, MDIO_OUT, MDIO_OE;
  logic        MDIO_IN, MDIO_DONE, MEM_WR, MEM_RD;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA, RD_DATA;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdio_receiver #(.PHY_ADDR(PHY)) dut (
    .clk       (clk),
    .reset     (reset),
    .MDC       (MDC),
    .MDIO_OUT  (MDIO_OUT),
    .MDIO_OE   (MDIO_OE),
    .MDIO_IN   (MDIO_IN),
    .MDIO_DONE (MDIO_DONE),
    .ADDR      (ADDR),
    .WR_DATA   (WR_DATA),
    .MEM_WR    (MEM_WR),
    .MEM_RD    (MEM_RD),
    .RD_DATA   (RD_DATA)
  );

  // Register memory: data valid the clk after MEM_RD, noise otherwise.
  logic [15:0] mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (MEM_WR) begin
      mem[ADDR] <= WR_DATA;
    end
    RD_DATA <= MEM_RD ? mem[ADDR] : 16'($urandom);
  end

  // Strobe monitor: cumulative event counts and captured bus values.
  int n_wr = 0, n_rd = 0, n_done = 0, n_both = 0, n_hi = 0;
  logic [4:0]  wr_addr, rd_addr;
  logic [15:0] wr_dat;
  always @(negedge clk) begin
    if (MEM_WR) begin
      n_wr    <= n_wr + 1;
      wr_addr <= ADDR;
      wr_dat  <= WR_DATA;
    end
    if (MEM_RD) begin
      n_rd    <= n_rd + 1;
      rd_addr <= ADDR;
    end
    if (MDIO_DONE)         n_done <= n_done + 1;
    if (MEM_WR && MEM_RD)  n_both <= n_both + 1;
    if (MDIO_IN === 1'b1)  n_hi   <= n_hi + 1;
  end

  // Reference model state.
  logic [15:0] ref_mem [32];
  logic [4:0]  exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                     input logic [4:0] phy, input logic [4:0] ra,
                                     input logic [15:0] d);
    return {st, op, phy, ra, 2'b10, d};
  endfunction

  // Generator: MDC low 4 clks then high 4 clks per bit; samples MDIO_IN
  // just before the rises of indices 16..31.
  task automatic drive(input logic [31:0] f, input int nbits, input int oe_off,
                       output logic [15:0] bits);
    bits = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      MDC      = 1'b0;
      MDIO_OE  = (i < oe_off);
      MDIO_OUT = (i < oe_off) ? f[31-i] : 1'($urandom);
      repeat (3) @(negedge clk);
      if (i >= 16) bits[31-i] = MDIO_IN;
      @(negedge clk);
      MDC = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  // Sends one frame and checks all of its externally visible effects.
  task automatic run_frame(input string tag, input logic [31:0] f, input int nbits,
                           input int oe_off);
    int wr0, rd0_l, dn0, hi0_l;
    logic hdr_ok, is_wr, is_rd, exp_wr;
    logic [4:0]  ra;
    logic [15:0] got;
    wr0 = n_wr; rd0_l = n_rd; dn0 = n_done; hi0_l = n_hi;
    ra = f[22:18];
    hdr_ok = (f[31:30] == 2'b01) && (f[29:28] == 2'b01 || f[29:28] == 2'b10)
             && (f[27:23] == PHY) && (nbits >= 14);
    is_wr  = hdr_ok && f[29:28] == 2'b01 && nbits == 32;
    is_rd  = hdr_ok && f[29:28] == 2'b10 && nbits == 32;
    exp_wr = is_wr && oe_off >= 32;
    drive(f, nbits, oe_off, got);
    if (hdr_ok) exp_addr = ra;
    check({tag, ":wr_cnt"},   32'(n_wr - wr0),     32'(exp_wr));
    check({tag, ":rd_cnt"},   32'(n_rd - rd0_l),   32'(is_rd));
    check({tag, ":done_cnt"}, 32'(n_done - dn0),   32'(exp_wr || is_rd));
    check({tag, ":wr_rd_overlap"}, 32'(n_both), 32'h0);
    check({tag, ":addr"},     32'(ADDR),           32'(exp_addr));
    if (exp_wr) begin
      check({tag, ":wr_addr"}, 32'(wr_addr), 32'(ra));
      check({tag, ":wr_data"}, 32'(wr_dat),  32'(f[15:0]));
      ref_mem[ra] = f[15:0];
    end
    if (is_rd) begin
      check({tag, ":rd_addr"}, 32'(rd_addr), 32'(ra));
      check({tag, ":rd_bits"}, 32'(got),     32'(ref_mem[ra]));
    end else begin
      check({tag, ":mdio_quiet"}, 32'(n_hi - hi0_l), 32'h0);
    end
  endtask

  logic [15:0] bits;
  int          rd0, d0, hi0, sel;
  logic [1:0]  r_st, r_op;
  logic [4:0]  r_phy, r_ra;
  logic [15:0] r_d;

  initial begin
    reset = 1'b1; MDC = 1'b0; MDIO_OUT = 1'b0; MDIO_OE = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    exp_addr = '0;
    repeat (4) @(negedge clk);
    check("reset:mdio_in", 32'(MDIO_IN),   32'h0);
    check("reset:done",    32'(MDIO_DONE), 32'h0);
    check("reset:addr",    32'(ADDR),      32'h0);
    check("reset:wr_data", 32'(WR_DATA),   32'h0);
    check("reset:mem_wr",  32'(MEM_WR),    32'h0);
    check("reset:mem_rd",  32'(MEM_RD),    32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Basic write, then write+read of register 3.
    run_frame("wr_abcd", mk(2'b01, 2'b01, PHY, 5'd5, 16'hABCD), 32, 32);
    run_frame("wr_1234", mk(2'b01, 2'b01, PHY, 5'd3, 16'h1234), 32, 32);
    run_frame("rd_1234", mk(2'b01, 2'b10, PHY, 5'd3, 16'h0000), 32, 14);

    // Bad start, then a write issued straight after.
    run_frame("bad_st",   mk(2'b11, 2'b01, PHY, 5'd7, 16'h0000), 2, 32);
    run_frame("wr_after", mk(2'b01, 2'b01, PHY, 5'd7, 16'h5A5A), 32, 32);

    // Foreign PHY address on a read.
    run_frame("phy7_rd",  mk(2'b01, 2'b10, 5'd7, 5'd5, 16'h0000), 32, 14);
    run_frame("rd_5",     mk(2'b01, 2'b10, PHY, 5'd5, 16'h0000), 32, 14);

    // Write aborted by OE low at index 20, then a normal write.
    run_frame("wr_abort", mk(2'b01, 2'b01, PHY, 5'd5, 16'h0F0F), 32, 20);
    run_frame("wr_next",  mk(2'b01, 2'b01, PHY, 5'd12, 16'hC3C3), 32, 32);
    run_frame("rd_7",     mk(2'b01, 2'b10, PHY, 5'd7, 16'h0000), 32, 14);

    // Reset during index 25 of a read returning all ones.
    run_frame("rst_pre",  mk(2'b01, 2'b01, PHY, 5'd9, 16'hFFFF), 32, 32);
    rd0 = n_rd; d0 = n_done;
    drive(mk(2'b01, 2'b10, PHY, 5'd9, 16'h0000), 26, 14, bits);
    check("rst:partial_bits", 32'(bits[15:6]), 32'h3FF);
    reset = 1'b1;
    @(negedge clk);
    check("rst:mdio_in", 32'(MDIO_IN),   32'h0);
    check("rst:done",    32'(MDIO_DONE), 32'h0);
    check("rst:addr",    32'(ADDR),      32'h0);
    check("rst:wr_data", 32'(WR_DATA),   32'h0);
    check("rst:mem_wr",  32'(MEM_WR),    32'h0);
    check("rst:mem_rd",  32'(MEM_RD),    32'h0);
    MDC = 1'b0; MDIO_OE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    exp_addr = '0;
    @(negedge clk);
    hi0 = n_hi;
    repeat (40) @(negedge clk);
    check("rst:no_done",    32'(n_done - d0), 32'h0);
    check("rst:rd_once",    32'(n_rd - rd0),  32'h1);
    check("rst:mdio_quiet", 32'(n_hi - hi0),  32'h0);
    run_frame("post_rst_wr", mk(2'b01, 2'b01, PHY, 5'd9, 16'h8001), 32, 32);
    run_frame("post_rst_rd", mk(2'b01, 2'b10, PHY, 5'd9, 16'h0000), 32, 14);

    // Randomised frame mix.
    for (int k = 0; k < 40; k++) begin
      sel   = int'($urandom_range(0, 9));
      r_st  = 2'b01;
      r_op  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      r_phy = PHY;
      r_ra  = 5'($urandom);
      r_d   = 16'($urandom);
      case (sel)
        0: begin
          r_st = 2'($urandom_range(0, 2));
          if (r_st == 2'b01) r_st = 2'b11;
          run_frame("rnd_bad_st", mk(r_st, r_op, r_phy, r_ra, r_d), 2, 32);
        end
        1: begin
          r_phy = 5'($urandom_range(1, 31));
          run_frame("rnd_bad_phy", mk(r_st, r_op, r_phy, r_ra, r_d), 32, 14);
        end
        2: begin
          r_op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
          run_frame("rnd_bad_op", mk(r_st, r_op, r_phy, r_ra, r_d), 32, 32);
        end
        3: run_frame("rnd_wr_abort", mk(r_st, 2'b01, r_phy, r_ra, r_d), 32,
                     int'($urandom_range(14, 31)));
        4, 5, 6: run_frame("rnd_wr", mk(r_st, 2'b01, r_phy, r_ra, r_d), 32, 32);
        default: run_frame("rnd_rd", mk(r_st, 2'b10, r_phy, r_ra, r_d), 32, 14);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_receiver.md
Name:
mdio_receiver

Overview:
- PHY-side (responder) end of the MDIO management interface; connects to the MDIO generator's MDC, MDIO_OUT and MDIO_OE outputs and drives its MDIO_IN input.
- Deserialises 32-bit clause-22 frames: ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16), MSB first.
- On a write frame, issues a single-cycle write to the register memory.
- On a read frame, fetches the register and serialises it back on MDIO_IN.

Parameters:
PHY_ADDR, 5'd0, PHY address this block answers to; frames with any other PHYAD are ignored.

Ports:
clk  in  1  system clock; MDC is derived from it; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
MDC  in  1  management clock from the generator.
MDIO_OUT  in  1  serial data from the generator.
MDIO_OE  in  1  generator output-enable; 1 = generator drives the line.
MDIO_IN  out  1  serial read data to the generator.
MDIO_DONE  out  1  one-clk pulse at the end of each accepted frame.
ADDR  out  5  register address (REGAD) to the memory.
WR_DATA  out  16  write data to the memory.
MEM_WR  out  1  one-clk write strobe.
MEM_RD  out  1  one-clk read strobe.
RD_DATA  in  16  memory read data; valid in the clk after MEM_RD.

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; bit counter is 0. Reset mid-frame aborts with no memory strobe.
- Edge detection: mdc_q <= MDC; rise = MDC & ~mdc_q; fall = ~MDC & mdc_q. Bits are sampled from MDIO_OUT only on rise.
- Bit index: a 5-bit counter, 0..31, increments on each rise inside a frame.
- IDLE: on a rise with MDIO_OE=1, capture the bit (index 0) and go to HEADER.
- HEADER (indices 0-13):
  - ST must equal 01; otherwise return to IDLE at index 1.
  - OP 01 = write, OP 10 = read; 00 or 11 go to SKIP.
  - PHYAD != PHY_ADDR goes to SKIP.
  - At the rise of index 13, ADDR <= REGAD.
- WRITE (indices 14-31):
  - TA bits are sampled and ignored.
  - DATA is shifted into WR_DATA.
  - MDIO_OE=0 at any rise aborts to IDLE with no MEM_WR.
  - On the clk after the index-31 rise, MEM_WR=1 and MDIO_DONE=1 for exactly one clk, then IDLE.
- READ:
  - One clk after the index-13 rise: MEM_RD=1 for one clk.
  - Next clk: RD_DATA is latched into the shift register.
  - Indices 14-31 are counted on MDC rises regardless of MDIO_OE.
  - MDIO_IN=0 through TA.
  - On the first fall after the index-15 rise, MDIO_IN <= D15; each later fall shifts out the next bit, down to D0.
  - On the clk after the index-31 rise: MDIO_DONE pulses for one clk, MDIO_IN <= 0, then IDLE.
- SKIP: count rises to index 31, then IDLE. No strobes, no MDIO_DONE, MDIO_IN stays 0.
- MEM_WR and MEM_RD are never both 1. ADDR and WR_DATA hold their values until the next frame updates them.
- A frame starting in the clk right after MDIO_DONE is accepted: IDLE reacts the same cycle.

Decomposition:
- Package mdio_pkg holds:
  - ST_CODE = 2'b01, OP_WRITE = 2'b01, OP_READ = 2'b10.
  - FRAME_BITS = 32, HDR_LAST = 13, TA_LAST = 15.
  - State encoding IDLE, HEADER, WRITE, READ, SKIP.
- Sub-module mdc_edge_detect produces rise and fall from clk, reset and MDC.

Test Plan:
- Write frame 01_01_00000_00101_10_ABCD, PHY_ADDR=0 -> one clk after the 32nd rise: ADDR=5, WR_DATA=16'hABCD, MEM_WR=1 and MDIO_DONE=1 for one clk; MEM_RD never asserted.
- Read frame to REGAD 3, memory returns 16'h1234, MDIO_OE dropped at index 14 -> MEM_RD pulses once with ADDR=3; MDIO_IN presents 0001001000110100 MSB first on the 16 MDC falls after the index-15 rise; MDIO_DONE pulses once.
- Bad start: frame beginning 11 -> return to IDLE; no strobes; a valid write issued immediately after completes correctly.
- PHYAD=7 with PHY_ADDR=0, read op -> no MEM_RD, MDIO_IN stays 0, no MDIO_DONE; FSM back in IDLE after 32 rises.
- Write frame with MDIO_OE forced to 0 at index 20 -> no MEM_WR, no MDIO_DONE; next frame is accepted normally.
- reset asserted at index 25 of a read -> all outputs 0 next clk; MDIO_IN stays 0; no MDIO_DONE.
